mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and wb_stage.
- Accepts one pipeline_bus_t instruction at a time and issues loads/stores on a req/gnt/rvalid data-memory port.
- Aligns and extends load data into rd_res, then presents a registered bus plus a bypass bus to writeback.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 256: cycles spent in REQ+WAIT before the access is aborted; 0 disables the timeout. Counter is 16 bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- bus_i  in  core::pipeline_bus_t  instruction from execute; rd_res carries the ALU result, which is the address for memory ops.
- valid_i  in  1  bus_i holds a real instruction.
- store_data_i  in  32  rs2 value for stores.
- ready_o  out  1  stage can accept bus_i this cycle.
- stall_o  out  1  upstream must hold; equals valid_i & ~ready_o.
- mem_bus_o  out  core::pipeline_bus_t  registered bus to wb_stage.
- valid_o  out  1  mem_bus_o valid; one-cycle pulse per instruction.
- err_o  out  1  registered alongside valid_o; access aborted (timeout or misalign).
- mem_bp_o  out  core::bypass_bus_t  forwarding from mem_bus_o.
- dmem_req_o  out  1  request.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  32  word-aligned address, {addr[31:2], 2'b00}.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  load data valid; earliest one cycle after gnt.
- dmem_rdata_i  in  32  load data.

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE; timeout counter cleared.
  - dmem_req_o, dmem_we_o, valid_o and err_o are 0; dmem_be_o, dmem_addr_o and dmem_wdata_o are 0.
  - mem_bus_o is a bubble: all zero with mem_op=MEM_NOP, alu_op=ALU_NOP, format=NOP, instr=I_NOP.
  - Reset mid-transaction abandons the access; no output is produced for it. An rvalid arriving in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT.
- ready_o = (state==IDLE).
- IDLE with valid_i and mem_op==MEM_NOP:
  - Next edge: mem_bus_o<=bus_i, valid_o=1, err_o=0. Latency 1.
- IDLE with valid_i and a load/store:
  - Capture bus_i and store_data_i; go to REQ.
- REQ:
  - dmem_req_o=1; addr, be, we and wdata are driven from the captured registers and held stable until gnt.
  - Store + gnt: next edge outputs the captured bus (valid_o=1) and returns to IDLE. Minimum store latency is 2.
  - Load + gnt: go to WAIT.
- WAIT:
  - dmem_req_o=0.
  - On rvalid: next edge outputs the bus with rd_res = extracted load value, valid_o=1; return to IDLE. Minimum load latency is 3.
- Store lanes (a=addr[1:0]):
  - MEM_SB: be=1<<a; wdata={4{d[7:0]}}.
  - MEM_SH: be = a[1] ? 4'b1100 : 4'b0011; wdata={2{d[15:0]}}.
  - MEM_SW: be=4'b1111; wdata=d.
- Loads:
  - dmem_be_o follows the same lane rules; dmem_we_o=0.
  - MEM_LB/MEM_LBU: select byte a, then sign- or zero-extend.
  - MEM_LH/MEM_LHU: select halfword a[1], then sign- or zero-extend.
  - MEM_LW: full word.
- Timeout:
  - Counter increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES: drop req, return to IDLE, output the bus with rd forced to 0, valid_o=1, err_o=1.
  - A gnt or rvalid in the same cycle as the timeout wins; the access completes normally.
- Output register:
  - On cycles with no completion, mem_bus_o reloads the bubble and valid_o=0.
- Bypass:
  - mem_bp_o.rd = mem_bus_o.rd_res and mem_bp_o.rd_addr = mem_bus_o.rd when valid_o & ~err_o & (alu_op!=ALU_NOP or the instruction is a load).
  - Otherwise mem_bp_o is 0.
- No backpressure from wb_stage; it always consumes.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issue no memory request.
  - Next edge outputs the bus with rd=0, valid_o=1, err_o=1. Latency 1.
- Undefined:
  - Low address bits below the access size are ignored; lanes are chosen by the lane rules above, e.g. LW at 0x...3 reads the aligned word.

Test Plan:
- Back-to-back ALU ops (alu_op=ADD, rd=5, rd_res=0x1234), gnt held 1 -> valid_o each cycle, 1-cycle latency; mem_bp_o.rd=0x1234, rd_addr=5; dmem_req_o stays 0.
- SB with addr=0x1002, data=0xAB, gnt one cycle after req -> be=4'b0100, wdata=0xABABABAB, addr=0x1000; valid_o 2 cycles after accept; stall_o high while valid_i is held.
- LB at addr 0x2003, rdata=0x80FFFFFF (rvalid 2 cycles after gnt) -> rd_res=0xFFFFFF80. LBU at the same address and data -> rd_res=0x00000080. LHU at 0x2002, rdata=0x8001xxxx -> rd_res=0x00008001.
- TIMEOUT_CYCLES=4, gnt never asserted -> req drops after 4 cycles; valid_o=1, err_o=1, mem_bus_o.rd=0, mem_bp_o=0; the next instruction is accepted.
- rst asserted while in WAIT, rvalid arrives the cycle after reset -> no valid_o, mem_bus_o is the bubble, ready_o=1.
- With MEM_MISALIGN_TRAP_EN, LW at 0x3001 -> no dmem_req_o, err_o=1 after 1 cycle. Without it, the same LW issues addr=0x3000, be=4'b1111.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: sits between execute and wb_stage, issues loads and
// stores on a req/gnt/rvalid data port, aligns and extends load data, and presents a
// registered result bus plus a bypass bus to writeback.
//
// Optional build macro: MEM_MISALIGN_TRAP_EN. When it is defined, misaligned halfword and
// word accesses are not sent to memory and complete with err_o set instead. When it is
// undefined, the low address bits below the access size are ignored.

package core;

  typedef enum logic [5:0] {
    I_NOP, I_ADD, I_ADDI, I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW
  } instr_t;

  typedef enum logic [2:0] {
    NOP, R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE
  } format_t;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU
  } alu_op_t;

  typedef enum logic [3:0] {
    MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_t;

  typedef struct packed {
    logic [31:0] pc;
    instr_t      instr;
    format_t     format;
    alu_op_t     alu_op;
    mem_op_t     mem_op;
    logic [4:0]  rd;
    logic [31:0] rd_res;
  } pipeline_bus_t;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd;
  } bypass_bus_t;

endpackage

module mem_stage
  import core::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  pipeline_bus_t bus_i,
  input  logic          valid_i,
  input  logic [31:0]   store_data_i,
  output logic          ready_o,
  output logic          stall_o,
  output pipeline_bus_t mem_bus_o,
  output logic          valid_o,
  output logic          err_o,
  output bypass_bus_t   mem_bp_o,
  output logic          dmem_req_o,
  output logic          dmem_we_o,
  output logic [31:0]   dmem_addr_o,
  output logic [3:0]    dmem_be_o,
  output logic [31:0]   dmem_wdata_o,
  input  logic          dmem_gnt_i,
  input  logic          dmem_rvalid_i,
  input  logic [31:0]   dmem_rdata_i
);

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit MisalignTrapEn = 1'b1;
`else
  localparam bit MisalignTrapEn = 1'b0;
`endif

  localparam pipeline_bus_t Bubble = '{
    pc:     32'h0,
    instr:  I_NOP,
    format: NOP,
    alu_op: ALU_NOP,
    mem_op: MEM_NOP,
    rd:     5'h0,
    rd_res: 32'h0
  };

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_t;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------

  function automatic logic is_load(input mem_op_t op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Byte lanes touched by an access; identical for loads and stores of the same size.
  function automatic logic [3:0] lane_be(input mem_op_t op, input logic [1:0] a);
    logic [3:0] be;
    unique case (op)
      MEM_SB, MEM_LB, MEM_LBU: be = 4'b0001 << a;
      MEM_SH, MEM_LH, MEM_LHU: be = a[1] ? 4'b1100 : 4'b0011;
      MEM_SW, MEM_LW:          be = 4'b1111;
      default:                 be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data is replicated across lanes so the memory only needs to honour be.
  function automatic logic [31:0] lane_wdata(input mem_op_t op, input logic [31:0] d);
    logic [31:0] w;
    unique case (op)
      MEM_SB:  w = {4{d[7:0]}};
      MEM_SH:  w = {2{d[15:0]}};
      MEM_SW:  w = d;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input mem_op_t op, input logic [1:0] a,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    unique case (a)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = a[1] ? rdata[31:16] : rdata[15:0];
    unique case (op)
      MEM_LB:  r = {{24{b[7]}}, b};
      MEM_LBU: r = {24'h0, b};
      MEM_LH:  r = {{16{h[15]}}, h};
      MEM_LHU: r = {16'h0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input mem_op_t op, input logic [1:0] a);
    logic m;
    unique case (op)
      MEM_LH, MEM_LHU, MEM_SH: m = a[0];
      MEM_LW, MEM_SW:          m = (a != 2'b00);
      default:                 m = 1'b0;
    endcase
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------

  state_t        state_q, state_d;
  pipeline_bus_t bus_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [15:0]   cnt_q, cnt_d;
  logic          cap_en;

  pipeline_bus_t mem_bus_q, mem_bus_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic [16:0]   cnt_next;
  logic          timeout_hit;

  // The counter counts cycles spent in REQ+WAIT; the timeout fires on the cycle in which
  // the incremented count reaches the limit. >= keeps a grant that beat the timeout into
  // WAIT from running on forever.
  assign cnt_next    = {1'b0, cnt_q} + 17'd1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (32'(cnt_next) >= TIMEOUT_CYCLES);

  // Next-state, capture and completion logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_en    = 1'b0;
    mem_bus_d = Bubble;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = 16'h0;
        if (valid_i) begin
          if (bus_i.mem_op == MEM_NOP) begin
            mem_bus_d = bus_i;
            valid_d   = 1'b1;
          end else if (MisalignTrapEn && misaligned(bus_i.mem_op, bus_i.rd_res[1:0])) begin
            mem_bus_d    = bus_i;
            mem_bus_d.rd = 5'h0;
            valid_d      = 1'b1;
            err_d        = 1'b1;
          end else begin
            cap_en  = 1'b1;
            state_d = StReq;
          end
        end
      end

      StReq: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_next[15:0];
        if (dmem_gnt_i) begin
          if (is_store(bus_q.mem_op)) begin
            mem_bus_d = bus_q;
            valid_d   = 1'b1;
            state_d   = StIdle;
          end else begin
            state_d = StWait;
          end
        end else if (timeout_hit) begin
          mem_bus_d    = bus_q;
          mem_bus_d.rd = 5'h0;
          valid_d      = 1'b1;
          err_d        = 1'b1;
          state_d      = StIdle;
        end
      end

      StWait: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_next[15:0];
        if (dmem_rvalid_i) begin
          mem_bus_d        = bus_q;
          mem_bus_d.rd_res = load_extract(bus_q.mem_op, bus_q.rd_res[1:0], dmem_rdata_i);
          valid_d          = 1'b1;
          state_d          = StIdle;
        end else if (timeout_hit) begin
          mem_bus_d    = bus_q;
          mem_bus_d.rd = 5'h0;
          valid_d      = 1'b1;
          err_d        = 1'b1;
          state_d      = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State register, capture registers and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 16'h0;
      bus_q     <= Bubble;
      be_q      <= 4'h0;
      wdata_q   <= 32'h0;
      mem_bus_q <= Bubble;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_bus_q <= mem_bus_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      if (cap_en) begin
        bus_q   <= bus_i;
        be_q    <= lane_be(bus_i.mem_op, bus_i.rd_res[1:0]);
        wdata_q <= lane_wdata(bus_i.mem_op, store_data_i);
      end
    end
  end

  // Memory port is driven only in REQ, straight from the captured registers.
  always_comb begin
    dmem_req_o   = (state_q == StReq);
    dmem_we_o    = 1'b0;
    dmem_addr_o  = 32'h0;
    dmem_be_o    = 4'h0;
    dmem_wdata_o = 32'h0;
    if (state_q == StReq) begin
      dmem_we_o    = is_store(bus_q.mem_op);
      dmem_addr_o  = {bus_q.rd_res[31:2], 2'b00};
      dmem_be_o    = be_q;
      dmem_wdata_o = wdata_q;
    end
  end

  // Forwarding from the registered result; only clean results that write rd are exposed.
  always_comb begin
    mem_bp_o = '0;
    if (valid_q && !err_q && ((mem_bus_q.alu_op != ALU_NOP) || is_load(mem_bus_q.mem_op))) begin
      mem_bp_o.rd      = mem_bus_q.rd_res;
      mem_bp_o.rd_addr = mem_bus_q.rd;
    end
  end

  assign ready_o   = (state_q == StIdle);
  assign stall_o   = valid_i & ~ready_o;
  assign mem_bus_o = mem_bus_q;
  assign valid_o   = valid_q;
  assign err_o     = err_q;

endmodule
